call_ret_queue: RTL and testbench

In-order tracking queue between fetch/decode and the return address stack (RAS). Records every fetched call and return in program order. At retirement, converts the oldest entry into the RAS update strobes (push on call, pop on return, push-at-pop on a combined call+return). Discards all in-flight entries on a pipeline squash so the RAS is only ever updated by committed control flow.

---
 rtl/call_ret_queue.sv | 116 +++++++++++
 tb/tb_call_ret_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/call_ret_queue.sv
// rtl/call_ret_queue.sv - in-order call/return tracking queue driving RAS push/pop strobes at retirement
// Optional retire-PC checker and sticky crq_err output: define CRQ_CHECK_EN.
module call_ret_queue #(
  parameter int CRQ_SIZE = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          if_valid,
  input  logic                          if_is_call,
  input  logic                          if_is_ret,
  input  logic [31:0]                   if_pc,
  output logic                          if_ready,
  input  logic                          rt_valid,
  input  logic [31:0]                   rt_pc,
  input  logic                          squash,
  output logic                          ras_write_en,
  output logic                          ras_clear_en,
  output logic [31:0]                   ras_pc,
`ifdef CRQ_CHECK_EN
  output logic                          crq_err,
`endif
  output logic [$clog2(CRQ_SIZE):0]     count
);

  localparam int PW = $clog2(CRQ_SIZE);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q   [CRQ_SIZE];
  logic          call_q [CRQ_SIZE];
  logic          ret_q  [CRQ_SIZE];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ras_write_en_q, ras_clear_en_q;
  logic [31:0]   ras_pc_q;
  logic          do_enq, do_ret;

  // Ready looks only at registered occupancy, so a full queue stalls even during a retire.
  assign if_ready = (count_q != CW'(CRQ_SIZE));
  assign count    = count_q;
  assign do_ret   = rt_valid && (count_q != '0);
  assign do_enq   = if_valid && if_ready && (if_is_call || if_is_ret) && !squash;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) tail_d = tail_q + PW'(1);
      if (do_ret) head_d = head_q + PW'(1);
      case ({do_enq, do_ret})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < CRQ_SIZE; i++) begin
        pc_q[i]   <= '0;
        call_q[i] <= 1'b0;
        ret_q[i]  <= 1'b0;
      end
    end else if (do_enq) begin
      pc_q[tail_q]   <= if_pc;
      call_q[tail_q] <= if_is_call;
      ret_q[tail_q]  <= if_is_ret;
    end
  end

  // A retire coinciding with squash is older than the flush, so its strobes still go out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      ras_write_en_q <= 1'b0;
      ras_clear_en_q <= 1'b0;
      ras_pc_q       <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      ras_write_en_q <= do_ret && call_q[head_q];
      ras_clear_en_q <= do_ret && ret_q[head_q];
      if (do_ret && call_q[head_q]) ras_pc_q <= pc_q[head_q];
    end
  end

  assign ras_write_en = ras_write_en_q;
  assign ras_clear_en = ras_clear_en_q;
  assign ras_pc       = ras_pc_q;

`ifdef CRQ_CHECK_EN
  logic crq_err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      crq_err_q <= 1'b0;
    end else if ((do_ret && (rt_pc != pc_q[head_q])) || (rt_valid && (count_q == '0))) begin
      crq_err_q <= 1'b1;
    end
  end

  assign crq_err = crq_err_q;
`else
  logic unused_rt_pc;
  assign unused_rt_pc = ^rt_pc;
`endif

endmodule

// File: tb/tb_call_ret_queue.sv
// tb/tb_call_ret_queue.sv - self-checking bench for call_ret_queue against a queue-based reference model
// Define CRQ_CHECK_EN to also exercise crq_err.
module tb_call_ret_queue;

  localparam int SIZE = 8;

  typedef struct {
    logic [31:0] pc;
    logic        call;
    logic        ret;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset, if_valid, if_is_call, if_is_ret, if_ready;
  logic        rt_valid, squash, ras_write_en, ras_clear_en;
  logic [31:0] if_pc, rt_pc, ras_pc;
  logic [$clog2(SIZE):0] count;
`ifdef CRQ_CHECK_EN
  logic        crq_err;
`endif

  ent_t        mdl[$];
  logic        exp_we, exp_ce, exp_err;
  logic [31:0] exp_pc;
  int          n_cmp = 0;
  int          n_fail = 0;

  call_ret_queue #(.CRQ_SIZE(SIZE)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_is_call(if_is_call),
    .if_is_ret(if_is_ret), .if_pc(if_pc), .if_ready(if_ready), .rt_valid(rt_valid),
    .rt_pc(rt_pc), .squash(squash), .ras_write_en(ras_write_en),
    .ras_clear_en(ras_clear_en), .ras_pc(ras_pc),
`ifdef CRQ_CHECK_EN
    .crq_err(crq_err),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  // Applies one cycle of inputs, advances the model by the queue's rules, then steps past the edge.
  task automatic drive(input logic rst, input logic v, input logic c, input logic r,
                       input logic [31:0] pc, input logic rv, input logic [31:0] rpc,
                       input logic sq);
    ent_t e;
    bit   rdy;
    reset = rst; if_valid = v; if_is_call = c; if_is_ret = r; if_pc = pc;
    rt_valid = rv; rt_pc = rpc; squash = sq;
    if (!rst) begin
      mdl.delete();
      exp_we = 0; exp_ce = 0; exp_pc = 0; exp_err = 0;
    end else begin
      rdy = (mdl.size() < SIZE);
      exp_we = 0; exp_ce = 0;
      if (rv && mdl.size() > 0) begin
        e = mdl.pop_front();
        exp_we = e.call;
        exp_ce = e.ret;
        if (e.call) exp_pc = e.pc;
        if (rpc != e.pc) exp_err = 1;
      end else if (rv) begin
        exp_err = 1;
      end
      if (sq) mdl.delete();
      else if (v && rdy && (c || r)) begin
        e.pc = pc; e.call = c; e.ret = r;
        mdl.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_reset();
    drive(0, 1, 1, 0, 32'h40, 1, 32'h40, 0);
    drive(0, 1, 1, 1, 32'h44, 1, 32'h44, 0);
    n_cmp++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", if_ready); end
    n_cmp++; if ({ras_write_en, ras_clear_en} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b%b expected 00", ras_write_en, ras_clear_en); end
    n_cmp++; if (ras_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ras_pc: got %h expected 0", ras_pc); end
`ifdef CRQ_CHECK_EN
    n_cmp++; if (crq_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", crq_err); end
`endif
    idle();
  endtask

  task automatic test_call_ret();
    drive(1, 1, 1, 0, 32'h100, 0, 32'h0, 0);
    drive(1, 1, 0, 1, 32'h200, 0, 32'h0, 0);
    n_cmp++; if (count !== 2) begin n_fail++; $display("FAIL cr_count: got %0d expected 2", count); end
    drive(1, 0, 0, 0, 32'h0, 1, 32'h100, 0);
    n_cmp++; if ({ras_write_en, ras_clear_en} !== {exp_we, exp_ce} || exp_we !== 1'b1)
      begin n_fail++; $display("FAIL cr_call_strobes: got %b%b expected 10", ras_write_en, ras_clear_en); end
    n_cmp++; if (ras_pc !== 32'h100) begin n_fail++; $display("FAIL cr_call_pc: got %h expected 100", ras_pc); end
    drive(1, 0, 0, 0, 32'h0, 1, 32'h200, 0);
    n_cmp++; if ({ras_write_en, ras_clear_en} !== 2'b01) begin n_fail++; $display("FAIL cr_ret_strobes: got %b%b expected 01", ras_write_en, ras_clear_en); end
    idle();
    n_cmp++; if ({ras_write_en, ras_clear_en} !== 2'b00) begin n_fail++; $display("FAIL cr_one_cycle: got %b%b expected 00", ras_write_en, ras_clear_en); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < SIZE; i++) drive(1, 1, 1, 0, 32'(i * 4), 0, 32'h0, 0);
    n_cmp++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", if_ready); end
    drive(1, 1, 1, 0, 32'h999, 1, 32'h0, 0);
    n_cmp++; if (count !== 32'(SIZE - 1)) begin n_fail++; $display("FAIL full_stall_count: got %0d expected %0d", count, SIZE - 1); end
    for (int i = 1; i < 3; i++) drive(1, 0, 0, 0, 32'h0, 1, 32'(i * 4), 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 32'h1000 + 32'(i * 4), 0, 32'h0, 0);
    n_cmp++; if (count !== 32'(SIZE)) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", count, SIZE); end
    for (int i = 0; i < SIZE; i++) begin
      drive(1, 0, 0, 0, 32'h0, 1, mdl[0].pc, 0);
      n_cmp++; if (ras_write_en !== 1'b1 || ras_pc !== exp_pc)
        begin n_fail++; $display("FAIL wrap_order[%0d]: got we=%b pc=%h expected we=1 pc=%h", i, ras_write_en, ras_pc, exp_pc); end
    end
    n_cmp++; if (count !== 0) begin n_fail++; $display("FAIL wrap_drain: got %0d expected 0", count); end
    idle();
  endtask

  task automatic test_squash();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 32'h2000 + 32'(i * 4), 0, 32'h0, 0);
    drive(1, 1, 1, 0, 32'h3000, 1, 32'h2000, 1);
    n_cmp++; if (ras_write_en !== 1'b1 || ras_pc !== 32'h2000) begin n_fail++; $display("FAIL sq_strobe: got we=%b pc=%h expected we=1 pc=2000", ras_write_en, ras_pc); end
    n_cmp++; if (count !== 0) begin n_fail++; $display("FAIL sq_count: got %0d expected 0", count); end
    n_cmp++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL sq_ready: got %b expected 1", if_ready); end
    idle();
    n_cmp++; if (count !== 0 || ras_write_en !== 1'b0) begin n_fail++; $display("FAIL sq_enq_lost: got count=%0d we=%b expected 0 0", count, ras_write_en); end
  endtask

  task automatic test_combined_empty();
    drive(1, 1, 1, 1, 32'h480, 0, 32'h0, 0);
    drive(1, 0, 0, 0, 32'h0, 1, 32'h480, 0);
    n_cmp++; if ({ras_write_en, ras_clear_en} !== 2'b11 || ras_pc !== 32'h480)
      begin n_fail++; $display("FAIL both_strobes: got %b%b pc=%h expected 11 pc=480", ras_write_en, ras_clear_en, ras_pc); end
    drive(1, 1, 0, 0, 32'h500, 1, 32'h0, 0);
    n_cmp++; if ({ras_write_en, ras_clear_en} !== 2'b00 || count !== 0)
      begin n_fail++; $display("FAIL empty_retire: got %b%b count=%0d expected 00 count=0", ras_write_en, ras_clear_en, count); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    logic [1:0]  ty;
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    for (int n = 0; n < 400; n++) begin
      ty  = 2'($urandom_range(0, 3));
      rpc = (mdl.size() > 0) ? mdl[0].pc : 32'h0;
      if ($urandom_range(0, 15) == 0) rpc = $urandom;
      drive(1, ($urandom_range(0, 3) != 0), ty[0], ty[1], {$urandom, 2'b00} & 32'h0000fffc,
            ($urandom_range(0, 2) == 0), rpc, ($urandom_range(0, 29) == 0));
      n_cmp++; if (count !== 32'(mdl.size()) || if_ready !== (mdl.size() < SIZE))
        begin n_fail++; $display("FAIL rnd_occ[%0d]: got count=%0d ready=%b expected count=%0d", n, count, if_ready, mdl.size()); end
      n_cmp++; if ({ras_write_en, ras_clear_en} !== {exp_we, exp_ce} || (exp_we && ras_pc !== exp_pc))
        begin n_fail++; $display("FAIL rnd_ras[%0d]: got %b%b pc=%h expected %b%b pc=%h", n, ras_write_en, ras_clear_en, ras_pc, exp_we, exp_ce, exp_pc); end
`ifdef CRQ_CHECK_EN
      n_cmp++; if (crq_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, crq_err, exp_err); end
`endif
    end
    drive(1, 1, 1, 0, 32'h700, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 32'h0, 1, 32'h700, 0);
    n_cmp++; if (count !== 0 || ras_write_en !== 1'b0 || ras_pc !== 32'h0)
      begin n_fail++; $display("FAIL mid_retire_reset: got count=%0d we=%b pc=%h expected 0 0 0", count, ras_write_en, ras_pc); end
    idle();
  endtask

`ifdef CRQ_CHECK_EN
  task automatic test_check();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    drive(1, 1, 1, 0, 32'h300, 0, 32'h0, 0);
    n_cmp++; if (crq_err !== 1'b0) begin n_fail++; $display("FAIL chk_pre: got %b expected 0", crq_err); end
    drive(1, 0, 0, 0, 32'h0, 1, 32'h304, 0);
    n_cmp++; if (crq_err !== 1'b1) begin n_fail++; $display("FAIL chk_set: got %b expected 1", crq_err); end
    n_cmp++; if (ras_write_en !== 1'b1 || ras_pc !== 32'h300) begin n_fail++; $display("FAIL chk_unchanged: got we=%b pc=%h expected 1 300", ras_write_en, ras_pc); end
    idle(); idle();
    n_cmp++; if (crq_err !== 1'b1) begin n_fail++; $display("FAIL chk_sticky: got %b expected 1", crq_err); end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    n_cmp++; if (crq_err !== 1'b0) begin n_fail++; $display("FAIL chk_reset: got %b expected 0", crq_err); end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_call_ret();
    test_fill_wrap();
    test_squash();
    test_combined_empty();
    test_random();
`ifdef CRQ_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
